// File: rtl/serial_sub_4.sv
// Bit-serial unsigned subtractor: one full-adder cell, LSB first.
// Computes a - b - bin as a + ~b + ~bin over WIDTH cycles.
module serial_sub_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;
    logic             last;
    logic             nb;

    assign last = (cnt == CW'(WIDTH - 1));

    // Single full-adder cell: current a bit plus inverted b bit plus carry
    always_comb begin
        nb = ~b_sh[0];
        s  = a_sh[0] ^ nb ^ carry;
        co = (a_sh[0] & nb) | (a_sh[0] & carry) | (nb & carry);
    end

    // Next-state and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand capture, serial shift and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else if (state != RUN) begin
            if (start) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= ~bin;
                cnt   <= '0;
            end
        end else begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= {s, res[WIDTH-1:1]};
            carry <= co;
            if (last) begin
                diff <= {s, res[WIDTH-1:1]};
                bout <= ~co;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_4.sv
// Self-checking bench for serial_sub_4 (WIDTH=4).
// Reference: plain integer a - b - bin.
module tb_serial_sub_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;

    int           n_chk = 0;
    int           n_fail = 0;
    int           edges;
    int           dones;
    logic [W-1:0] prev_diff;
    logic         prev_bout;

    always #5 clk = ~clk;

    serial_sub_4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
        if (done === 1'b1) dones++;
    endtask

    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic tbin);
        a     = ta;
        b     = tb2;
        bin   = tbin;
        start = 1'b1;
        tick();
        edges = 0;
        dones = 0;
        start = 1'b0;
        check("busy_run", 32'(busy), 32'd1);
        check("hold_diff", 32'(diff), 32'(prev_diff));
        check("hold_bout", 32'(bout), 32'(prev_bout));
    endtask

    task automatic finish_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                             input logic tbin, input bit noise);
        int           r;
        logic [W-1:0] ed;
        logic         eb;
        r  = int'(ta) - int'(tb2) - int'(tbin);
        ed = r[W-1:0];
        eb = (r < 0);
        while (done !== 1'b1 && edges < 3 * W) begin
            if (busy === 1'b1 && edges == 2)
                check("run_hold", 32'(diff), 32'(prev_diff));
            if (noise) begin
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom);
                start = 1'($urandom);
            end
            tick();
        end
        start = 1'b0;
        check("latency", 32'(edges), 32'(W));
        check("diff", 32'(diff), 32'(ed));
        check("bout", 32'(bout), 32'(eb));
        check("busy_done", 32'(busy), 32'd0);
        check("one_done", 32'(dones), 32'd1);
        prev_diff = ed;
        prev_bout = eb;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        edges     = 0;
        dones     = 0;
        prev_diff = '0;
        prev_bout = 1'b0;

        #12;
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // first edge after reset release accepts start
        launch(4'b0110, 4'b0011, 1'b0);
        finish_op(4'b0110, 4'b0011, 1'b0, 1'b0);
        tick();
        check("done_pulse", 32'(done), 32'd0);

        launch(4'b0000, 4'b0001, 1'b0);
        finish_op(4'b0000, 4'b0001, 1'b0, 1'b0);
        launch(4'b0000, 4'b0000, 1'b1);
        finish_op(4'b0000, 4'b0000, 1'b1, 1'b0);
        launch(4'b1111, 4'b1111, 1'b1);
        finish_op(4'b1111, 4'b1111, 1'b1, 1'b0);
        launch(4'b0101, 4'b0101, 1'b0);
        finish_op(4'b0101, 4'b0101, 1'b0, 1'b0);

        // second start mid-run with other operands is ignored
        launch(4'b0101, 4'b0010, 1'b1);
        a     = 4'b1001;
        b     = 4'b0100;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_op(4'b0101, 4'b0010, 1'b1, 1'b0);

        // start held across DONE: straight back into RUN
        launch(4'b0110, 4'b0011, 1'b0);
        finish_op(4'b0110, 4'b0011, 1'b0, 1'b0);
        launch(4'b1000, 4'b0001, 1'b0);
        check("b2b_nodone", 32'(done), 32'd0);
        finish_op(4'b1000, 4'b0001, 1'b0, 1'b0);

        // reset during the second RUN cycle aborts
        launch(4'b0110, 4'b0011, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        prev_diff = '0;
        prev_bout = 1'b0;
        dones = 0;
        tick();
        tick();
        check("abort_nodone", 32'(dones), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(4'b0011, 4'b0001, 1'b0);
        finish_op(4'b0011, 4'b0001, 1'b0, 1'b0);

        // exhaustive sweep with random input noise while running
        for (int ia = 0; ia < (1 << W); ia++) begin
            for (int ib = 0; ib < (1 << W); ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    launch(W'(ia), W'(ib), 1'(ic));
                    finish_op(W'(ia), W'(ib), 1'(ic), 1'b1);
                    if ($urandom_range(3) == 0) begin
                        tick();
                        check("idle_done", 32'(done), 32'd0);
                        check("idle_busy", 32'(busy), 32'd0);
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
